// File: rtl/io_timer.sv
// io_timer: interval timer of the RRIOT.
// 8-bit down-counter with a selectable prescaler, a sticky underflow flag and
// an active-low IRQ. After an underflow the counter runs at /1 until the next write.
// Reads are registered for one cycle so that the bus mux can OR the DO/OE pairs.
module io_timer #(
    parameter int DIV0 = 1,
    parameter int DIV1 = 8,
    parameter int DIV2 = 64,
    parameter int DIV3 = 1024,
    parameter int PS_W = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       we_n,
    input  logic [3:0] A,
    input  logic [7:0] DI,
    output logic [7:0] DO,
    output logic       OE,
    output logic       irq_n
);

    logic [7:0]      count;
    logic [PS_W-1:0] ps;
    logic [1:0]      sel;
    logic            fast;
    logic            flag;
    logic            irq_en;

    logic wr;
    logic rd_timer;
    logic rd_status;
    logic tick;
    logic uflow;
    logic unused_a2;

    // Prescaler reload value for a given ratio select.
    function automatic logic [PS_W-1:0] div_m1(input logic [1:0] s);
        case (s)
            2'b00:   div_m1 = PS_W'(DIV0 - 1);
            2'b01:   div_m1 = PS_W'(DIV1 - 1);
            2'b10:   div_m1 = PS_W'(DIV2 - 1);
            default: div_m1 = PS_W'(DIV3 - 1);
        endcase
    endfunction

    assign unused_a2 = A[2];

    // Decode bus access type and the timer tick / underflow conditions.
    always_comb begin
        wr        = enable & ~we_n;
        rd_timer  = enable & we_n & ~A[0];
        rd_status = enable & we_n & A[0];
        tick      = (ps == '0);
        uflow     = tick & (count == 8'h00);
    end

    // Counter, prescaler, flag and registered read port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= 8'h00;
            ps     <= '0;
            sel    <= 2'b00;
            fast   <= 1'b0;
            flag   <= 1'b0;
            irq_en <= 1'b0;
            DO     <= 8'h00;
            OE     <= 1'b0;
        end else begin
            OE <= 1'b0;
            DO <= 8'h00;
            if (wr) begin
                count  <= DI;
                sel    <= A[1:0];
                irq_en <= A[3];
                flag   <= 1'b0;
                fast   <= 1'b0;
                ps     <= div_m1(A[1:0]);
            end else begin
                if (tick) begin
                    // An underflow switches to /1 at once, so the next edge ticks too.
                    ps <= (fast | uflow) ? '0 : div_m1(sel);
                    if (uflow) begin
                        count <= 8'hFF;
                        flag  <= 1'b1;
                        fast  <= 1'b1;
                    end else begin
                        count <= count - 8'h01;
                    end
                end else begin
                    ps <= ps - 1'b1;
                end
                if (rd_timer) begin
                    DO     <= count;
                    OE     <= 1'b1;
                    irq_en <= A[3];
                    // A coincident underflow keeps the flag set.
                    if (!uflow) begin
                        flag <= 1'b0;
                    end
                end
                if (rd_status) begin
                    DO <= {flag, 7'b0};
                    OE <= 1'b1;
                end
            end
        end
    end

    assign irq_n = ~(flag & irq_en);

endmodule
